// File: rtl/vga_mem_viewer.sv
// rtl/vga_mem_viewer.sv - memory-bitmap VGA viewer with per-frame overlay modes
// Optional feature macro: CURSOR_EN (blinking cursor over one memory bit)
module vga_mem_viewer #(
   parameter int RAM_WIDTH               = 16,
   parameter int ADDR_WIDTH              = 10,
   parameter int BITS_PER_MEMORY_PIXEL_X = 3,
   parameter int BITS_PER_MEMORY_PIXEL_Y = 3,
   parameter int VIEW_W                  = 512,
   parameter int VIEW_H                  = 384,
   parameter int H_ACTIVE                = 640,
   parameter int H_FP                    = 16,
   parameter int H_SYNC                  = 96,
   parameter int H_BP                    = 48,
   parameter int V_ACTIVE                = 480,
   parameter int V_FP                    = 10,
   parameter int V_SYNC                  = 2,
   parameter int V_BP                    = 33
) (
   input  logic                          CLK_50,
   input  logic                          RESET,
   input  logic                          pix_ce,
   input  logic [1:0]                    mode,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_rd_en,
   input  logic [RAM_WIDTH-1:0]          mem_data,
   output logic [2:0]                    RED,
   output logic [2:0]                    GREEN,
   output logic [1:0]                    BLUE,
   output logic                          h_sync,
   output logic                          v_sync,
   output logic [9:0]                    pixel_x,
   output logic [9:0]                    pixel_y,
   output logic                          frame_start
`ifdef CURSOR_EN
   ,
   input  logic [ADDR_WIDTH-1:0]         cursor_addr,
   input  logic [$clog2(RAM_WIDTH)-1:0]  cursor_bit
`endif
);

   localparam int BPX = BITS_PER_MEMORY_PIXEL_X;
   localparam int BPY = BITS_PER_MEMORY_PIXEL_Y;
   localparam int BW  = $clog2(RAM_WIDTH);
   localparam int WSH = BPX + BW;
   localparam int WPR = VIEW_W >> WSH;

   localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG    = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] VIEW_X    = 10'(VIEW_W);
   localparam logic [9:0] VIEW_Y    = 10'(VIEW_H);
   localparam logic [9:0] WORD_MASK = 10'((RAM_WIDTH << BPX) - 1);
   localparam logic [9:0] BYTE_MASK = 10'((8 << BPX) - 1);
   localparam logic [9:0] PXX_MASK  = 10'((1 << BPX) - 1);
   localparam logic [9:0] PXY_MASK  = 10'((1 << BPY) - 1);

   logic [9:0]    hc, vc;
   logic [1:0]    mode_q;
   logic          in_view;

   // First pipeline stage: raster attributes of the pixel whose word is being read
   logic [9:0]    p1_x, p1_y;
   logic          p1_active, p1_view, p1_hs, p1_vs, p1_first;
   logic          p1_wb, p1_bb, p1_pb;
   logic [BW-1:0] p1_bit;

   logic [7:0]    rgb_next;
   logic          pix_bit;
   logic          cursor_hit;

`ifdef CURSOR_EN
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [5:0]            frame_cnt;
`endif

   // Raster counters advance one pixel per pix_ce
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         hc <= '0;
         vc <= '0;
      end else if (pix_ce) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
         end else begin
            hc <= hc + 10'd1;
         end
      end
   end

   // Overlay mode is frozen for a whole frame, sampled at the frame origin
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET)
         mode_q <= '0;
      else if (pix_ce && hc == '0 && vc == '0)
         mode_q <= mode;
   end

   // Read request goes out with the counters; the RAM answers one cycle later,
   // and gating with pix_ce keeps its output register stable between ticks
   assign in_view   = (hc < VIEW_X) && (vc < VIEW_Y);
   assign mem_rd_en = pix_ce && in_view && !RESET;
   assign mem_addr  = ADDR_WIDTH'(vc >> BPY) * ADDR_WIDTH'(WPR) + ADDR_WIDTH'(hc >> WSH);

   // Carry coordinates, sync and border flags alongside the outstanding read
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         p1_x      <= '0;
         p1_y      <= '0;
         p1_active <= 1'b0;
         p1_view   <= 1'b0;
         p1_hs     <= 1'b1;
         p1_vs     <= 1'b1;
         p1_first  <= 1'b0;
         p1_wb     <= 1'b0;
         p1_bb     <= 1'b0;
         p1_pb     <= 1'b0;
         p1_bit    <= '0;
      end else if (pix_ce) begin
         p1_x      <= hc;
         p1_y      <= vc;
         p1_active <= (hc < H_ACT) && (vc < V_ACT);
         p1_view   <= in_view;
         p1_hs     <= !((hc >= HS_BEG) && (hc < HS_END));
         p1_vs     <= !((vc >= VS_BEG) && (vc < VS_END));
         p1_first  <= (hc == '0) && (vc == '0);
         p1_wb     <= (hc & WORD_MASK) == '0;
         p1_bb     <= (hc & BYTE_MASK) == '0;
         p1_pb     <= ((hc & PXX_MASK) == '0) || ((vc & PXY_MASK) == '0);
         p1_bit    <= ~BW'(hc >> BPX);
      end
   end

`ifdef CURSOR_EN
   // Cursor address follows the pipeline; frame counter bit 5 drives the blink
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         p1_addr   <= '0;
         frame_cnt <= '0;
      end else begin
         if (pix_ce)
            p1_addr <= mem_addr;
         if (frame_start)
            frame_cnt <= frame_cnt + 6'd1;
      end
   end
`endif

   // Colour selection, highest priority first
   always_comb begin
      pix_bit    = mem_data[p1_bit];
      cursor_hit = 1'b0;
`ifdef CURSOR_EN
      cursor_hit = frame_cnt[5] && (p1_addr == cursor_addr) && (p1_bit == cursor_bit);
`endif
      if (!p1_active)
         rgb_next = 8'b000_000_00;
      else if (mode_q == 2'd3)
         rgb_next = 8'b111_000_00;
      else if (!p1_view)
         rgb_next = 8'b000_001_00;
      else if (mode_q == 2'd2 && p1_wb)
         rgb_next = 8'b000_000_11;
      else if (mode_q == 2'd2 && p1_bb)
         rgb_next = 8'b000_000_01;
      else if (mode_q != 2'd0 && p1_pb)
         rgb_next = 8'b111_000_00;
      else if (cursor_hit)
         rgb_next = pix_bit ? 8'b111_111_00 : 8'b011_011_00;
      else if (pix_bit)
         rgb_next = 8'b111_111_11;
      else
         rgb_next = 8'b001_001_01;
   end

   // Output register: everything the DAC sees changes on the same tick
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         RED         <= '0;
         GREEN       <= '0;
         BLUE        <= '0;
         h_sync      <= 1'b1;
         v_sync      <= 1'b1;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_start <= 1'b0;
      end else if (pix_ce) begin
         {RED, GREEN, BLUE} <= rgb_next;
         h_sync      <= p1_hs;
         v_sync      <= p1_vs;
         pixel_x     <= p1_x;
         pixel_y     <= p1_y;
         frame_start <= p1_first;
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_mem_viewer.sv
// tb/tb_vga_mem_viewer.sv - self-checking bench for vga_mem_viewer on a reduced raster
module tb_vga_mem_viewer;

   localparam int RW  = 16;
   localparam int AW  = 10;
   localparam int BPX = 2;
   localparam int BPY = 1;
   localparam int VW  = 128;
   localparam int VH  = 16;
   localparam int HA  = 160, HF = 8, HS = 16, HB = 8;
   localparam int VA  = 20,  VF = 2, VS = 3,  VB = 3;
   localparam int HT  = HA + HF + HS + HB;   // 192
   localparam int VT  = VA + VF + VS + VB;   // 28
   localparam int FT  = HT * VT;             // 5376

   logic           CLK_50 = 1'b0;
   logic           RESET  = 1'b1;
   logic           pix_ce = 1'b1;
   logic [1:0]     mode   = 2'd0;
   logic [AW-1:0]  mem_addr;
   logic           mem_rd_en;
   logic [RW-1:0]  mem_data = '0;
   logic [2:0]     RED, GREEN;
   logic [1:0]     BLUE;
   logic           h_sync, v_sync;
   logic [9:0]     pixel_x, pixel_y;
   logic           frame_start;

   logic [RW-1:0]  mem [0:(1<<AW)-1];
   logic [1:0]     frame_mode [0:63];
   int             checks = 0;
   int             fails  = 0;
   int             n      = 0;
   bit             half   = 1'b0;

   vga_mem_viewer #(
      .RAM_WIDTH(RW), .ADDR_WIDTH(AW),
      .BITS_PER_MEMORY_PIXEL_X(BPX), .BITS_PER_MEMORY_PIXEL_Y(BPY),
      .VIEW_W(VW), .VIEW_H(VH),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .CLK_50(CLK_50), .RESET(RESET), .pix_ce(pix_ce), .mode(mode),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
      .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .h_sync(h_sync), .v_sync(v_sync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
   );

   initial forever #5 CLK_50 = ~CLK_50;

   // pix_ce: every cycle, or every second cycle when half is set
   initial forever begin
      @(posedge CLK_50);
      #1;
      pix_ce = half ? ~pix_ce : 1'b1;
   end

   // Registered-read video RAM
   always @(posedge CLK_50)
      if (mem_rd_en) mem_data <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected colour of screen pixel (x,y) under overlay mode m
   function automatic logic [7:0] exp_rgb(input int x, input int y, input logic [1:0] m);
      logic [RW-1:0] w;
      int            widx, bitn;
      if (x >= HA || y >= VA) return 8'b000_000_00;
      if (m == 2'd3) return 8'b111_000_00;
      if (x >= VW || y >= VH) return 8'b000_001_00;
      if (m == 2'd2 && (x % (RW << BPX)) == 0) return 8'b000_000_11;
      if (m == 2'd2 && (x % (8 << BPX)) == 0) return 8'b000_000_01;
      if (m != 2'd0 && ((x % (1 << BPX)) == 0 || (y % (1 << BPY)) == 0)) return 8'b111_000_00;
      widx = ((y >> BPY) * (VW / (RW << BPX)) + x / (RW << BPX)) % (1 << AW);
      w    = mem[widx];
      bitn = RW - 1 - ((x >> BPX) % RW);
      return w[bitn] ? 8'b111_111_11 : 8'b001_001_01;
   endfunction

   // Model: n counts pixel ticks since reset; outputs show pixel n-2 of the raster
   initial begin
      bit         ce;
      logic [1:0] md;
      int         p, pos, x, y;
      forever begin
         @(posedge CLK_50);
         ce = pix_ce;
         md = mode;
         if (RESET) begin
            n = 0;
            continue;
         end
         if (ce) begin
            if (n % FT == 0) frame_mode[(n / FT) % 64] = md;
            n++;
         end
         #1;
         if (!RESET && n >= 2) begin
            p   = n - 2;
            pos = p % FT;
            x   = pos % HT;
            y   = pos / HT;
            chk("rgb", {RED, GREEN, BLUE}, exp_rgb(x, y, frame_mode[(p / FT) % 64]));
            chk("pixel_x", pixel_x, x);
            chk("pixel_y", pixel_y, y);
            chk("h_sync", h_sync, !(x >= HA + HF && x < HA + HF + HS));
            chk("v_sync", v_sync, !(y >= VA + VF && y < VA + VF + VS));
            chk("frame_start", frame_start, ce && x == 0 && y == 0);
         end
         @(negedge CLK_50);
         if (!RESET) begin
            pos = n % FT;
            x   = pos % HT;
            y   = pos / HT;
            if (pix_ce) begin
               chk("mem_rd_en", mem_rd_en, x < VW && y < VH);
               if (x < VW && y < VH)
                  chk("mem_addr", mem_addr, ((y >> BPY) * (VW / (RW << BPX)) + x / (RW << BPX)) % (1 << AW));
            end else begin
               chk("mem_rd_en_idle", mem_rd_en, 0);
            end
         end
      end
   end

   task automatic wait_at(input int x, input int y, output bit found);
      int k = 0;
      do begin
         @(posedge CLK_50);
         #1;
         k++;
      end while (!(pixel_x == x && pixel_y == y) && k < 3 * FT);
      found = (pixel_x == x && pixel_y == y);
      if (!found) begin
         checks++;
         fails++;
         $display("FAIL wait_pixel(%0d,%0d): not reached within %0d cycles", x, y, k);
      end
   endtask

   task automatic wait_pix(input string name, input int x, input int y, input logic [7:0] exp);
      bit found;
      wait_at(x, y, found);
      if (found) chk(name, {RED, GREEN, BLUE}, exp);
   endtask

   task automatic frame_len(input string name, input int exp_cycles, input bit sync_cnt);
      int cnt = 0, hl = 0, vl = 0;
      do begin
         @(posedge CLK_50);
         #1;
         cnt++;
         if (h_sync === 1'b0) hl++;
         if (v_sync === 1'b0) vl++;
      end while (frame_start !== 1'b1 && cnt < 2 * exp_cycles + 100);
      chk(name, cnt, exp_cycles);
      if (sync_cnt) begin
         chk("hsync_low_ticks", hl, 448);
         chk("vsync_low_ticks", vl, 576);
      end
   endtask

   initial begin
      bit found;
      int k;
      for (int i = 0; i < (1 << AW); i++) mem[i] = RW'($urandom);
      mem[0]  = 16'h8001;
      mem[12] = 16'hFFFF;

      repeat (3) @(posedge CLK_50);
      @(negedge CLK_50);
      RESET = 1'b0;

      // Reset in the middle of a line, while h_sync is low
      k = 0;
      while (h_sync !== 1'b0 && k < 2000) begin
         @(posedge CLK_50);
         #1;
         k++;
      end
      chk("hsync_reached", h_sync, 1'b0);
      #2;
      RESET = 1'b1;
      @(posedge CLK_50);
      #1;
      chk("rst_h_sync", h_sync, 1'b1);
      chk("rst_v_sync", v_sync, 1'b1);
      chk("rst_rgb", {RED, GREEN, BLUE}, 8'h00);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pixel_x", pixel_x, 0);
      chk("rst_frame_start", frame_start, 1'b0);
      @(negedge CLK_50);
      RESET = 1'b0;

      // frame_start two ticks after the counters leave reset at (0,0)
      @(posedge CLK_50);
      #1;
      chk("fs_tick1", frame_start, 1'b0);
      @(posedge CLK_50);
      #1;
      chk("fs_tick2", frame_start, 1'b1);

      frame_len("frame_len_full", 5376, 1'b1);

      // Frame 1, mode 0; switch to mode 2 mid-frame
      chk("px_0_0", {RED, GREEN, BLUE}, 8'hFF);
      wait_pix("px_8_0",    8,   0, 8'h25);
      wait_pix("px_60_0",   60,  0, 8'hFF);
      wait_pix("px_130_3",  130, 3, 8'h04);
      wait_at(0, 10, found);
      mode = 2'd2;
      wait_pix("px_0_12",   0,   12, 8'hFF);
      wait_pix("px_10_17",  10,  17, 8'h04);
      wait_pix("px_170_19", 170, 19, 8'h00);

      // Frame 2, mode 2 overlays
      wait_pix("m2_2_0",    2,  0, 8'hE0);
      wait_pix("m2_0_1",    0,  1, 8'h03);
      wait_pix("m2_4_1",    4,  1, 8'hE0);
      wait_pix("m2_5_1",    5,  1, 8'h25);
      wait_pix("m2_32_1",   32, 1, 8'h01);
      wait_pix("m2_64_1",   64, 1, 8'h03);
      wait_pix("m2_5_13",   5,  13, 8'hFF);
      mode = 2'd3;

      // Frame 3, solid red test
      wait_pix("m3_5_1",    5,   1, 8'hE0);
      wait_pix("m3_140_3",  140, 3, 8'hE0);
      wait_pix("m3_170_3",  170, 3, 8'h00);
      mode = 2'd0;
      half = 1'b1;

      // Frame 4, mode 0 at half pixel rate
      wait_pix("h_0_0",     0,   0, 8'hFF);
      wait_pix("h_8_0",     8,   0, 8'h25);
      wait_pix("h_130_3",   130, 3, 8'h04);
      k = 0;
      while (frame_start !== 1'b1 && k < 3 * FT) begin
         @(posedge CLK_50);
         #1;
         k++;
      end
      chk("fs_half_seen", frame_start, 1'b1);
      frame_len("frame_len_half", 10752, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/vga_mem_viewer.md
Name: vga_mem_viewer

Overview:
Parametrised successor of the memory-bitmap VGA renderer. It generates its own VGA timing, fetches video-memory words through a registered read port, and renders each memory bit as a block of screen pixels. Selectable grid/byte/word overlays are latched per frame. It sits between the CPU-visible video RAM and the board VGA DAC pins, all on CLK_50.

Parameters:
RAM_WIDTH, 16, bits per memory word (power of 2, 8..64)
ADDR_WIDTH, 10, video-memory word address width
BITS_PER_MEMORY_PIXEL_X, 3, log2 screen pixels per memory bit, horizontal
BITS_PER_MEMORY_PIXEL_Y, 3, log2 screen pixels per memory bit, vertical
VIEW_W, 512, viewport width in screen pixels (multiple of RAM_WIDTH<<BITS_PER_MEMORY_PIXEL_X)
VIEW_H, 384, viewport height in screen pixels
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
CLK_50  input  1  system clock
RESET  input  1  asynchronous, active-high reset
pix_ce  input  1  pixel-tick enable; all timing/pipeline state advances only when high
mode  input  2  0 plain, 1 pixel grid, 2 pixel+byte+word grid, 3 solid red test
mem_addr  output  ADDR_WIDTH  video-memory word address
mem_rd_en  output  1  read strobe
mem_data  input  RAM_WIDTH  read data, valid exactly 1 CLK_50 cycle after mem_rd_en
RED/GREEN/BLUE  output  3/3/2  colour
h_sync, v_sync  output  1  active-low sync
pixel_x, pixel_y  output  10  coordinates aligned with RGB
frame_start  output  1  1-cycle pulse, first pixel of frame on outputs

Behaviour:
- Reset (async): hc=vc=0, RGB=0, h_sync=v_sync=1, mem_rd_en=0, mem_addr=0, pixel_x=pixel_y=0, frame_start=0, mode_q=0.
- Counters: hc wraps at H_TOTAL-1 (sum of four H params) and increments vc; vc wraps at V_TOTAL-1. Both step only on pix_ce.
- Sync: h_sync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); same rule for v_sync on vc.
- Stage 0 (pix_ce): mem_rd_en=1 when hc<VIEW_W and vc<VIEW_H.
  mem_addr = (vc>>BPMP_Y)*WPR + (hc>>(BPMP_X+log2 RAM_WIDTH)), with WPR = VIEW_W>>(BPMP_X+log2 RAM_WIDTH), truncated to ADDR_WIDTH.
  Bit index b = RAM_WIDTH-1-((hc>>BPMP_X) mod RAM_WIDTH); the MSB is the leftmost bit.
- Stage 1: mem_data captured on the next pix_ce. This requires the pix_ce period to be at least 1 CLK_50 cycle, i.e. pix_ce high every cycle is legal.
- Stage 2: colour registered. RGB, syncs, pixel_x/y and frame_start all carry 2 pix_ce ticks of latency from the counters, and all are mutually aligned.
- mode is sampled into mode_q only at hc=0,vc=0. A mid-frame change takes effect next frame.
- Colour priority, highest first:
  - blanking (outside active area): 000/000/00
  - mode_q=3: 111/000/00
  - outside viewport: 000/001/00
  - word border (mode_q=2, hc mod (RAM_WIDTH<<BPMP_X)==0): 000/000/11
  - byte border (mode_q=2, hc mod (8<<BPMP_X)==0): 000/000/01
  - pixel border (mode_q>=1, hc or vc mod 2^BPMP==0): 111/000/00
  - bit set: 111/111/11
  - bit clear: 001/001/01
- pix_ce low: all registers hold, and mem_rd_en drops to 0 for that cycle.

Optional Feature:
CURSOR_EN:
- Defined: adds inputs cursor_addr[ADDR_WIDTH] and cursor_bit[log2 RAM_WIDTH], plus a 6-bit frame counter (reset 0, increments on frame_start).
- While counter[5]=1, the memory pixel at (cursor_addr, cursor_bit) renders 111/111/00 if set or 011/011/00 if clear.
- The cursor sits below all border priorities.
- Undefined: ports and counter absent; behaviour otherwise identical.

Test Plan:
- RESET high mid-line, pix_ce=1 -> next cycle h_sync=v_sync=1, RGB=0, mem_rd_en=0; after release, first frame_start follows 2 ticks after hc=vc=0.
- Free-run one frame -> h_sync low for 96 ticks starting hc=656, v_sync low for lines 490-491, 800x525 ticks per frame.
- mem_data=16'h8001 for addr 0, mode=0 -> pixels x0-7 and x120-127 of y0 are 111/111/11, x8-119 are 001/001/01; mem_addr=1 issued at hc=128.
- mode 0->2 changed at vc=100 -> current frame unchanged; next frame x=0/128 are 000/000/11, x=64 is 000/000/01, x=8 is 111/000/00.
- pix_ce toggled every 2nd cycle -> outputs identical to full-rate run, only spaced 2x; x=512..639 in active lines show 000/001/00.
- CURSOR_EN, cursor_addr=5, cursor_bit=15, data bit clear -> frames 32-63 show 011/011/00 at x=128..135, y=8..15 (interior only); frames 0-31 show 001/001/01.
